// File: rtl/frequency_sweep.sv
// Sweeps the DDS phase increment between start_M and stop_M, one step per dwell count of ticks.
// Optional crossing marker output enabled by defining FREQUENCY_SWEEP_MARKER_EN.
module frequency_sweep #(
  parameter int unsigned M_WIDTH     = 10,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [M_WIDTH-1:0]     start_M,
  input  logic [M_WIDTH-1:0]     stop_M,
  input  logic [M_WIDTH-1:0]     step_M,
  input  logic [DWELL_WIDTH-1:0] dwell,
`ifdef FREQUENCY_SWEEP_MARKER_EN
  input  logic [M_WIDTH-1:0]     marker_M,
  output logic                   marker,
`endif
  output logic [M_WIDTH-1:0]     phase_M,
  output logic                   busy,
  output logic                   sweep_done
);

  localparam int unsigned SUM_W = M_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [M_WIDTH-1:0]     phase_q, phase_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   wrap_q, wrap_d;
  logic [1:0]             mode_q, mode_d;
  logic [M_WIDTH-1:0]     start_q, start_d;
  logic [M_WIDTH-1:0]     stop_q, stop_d;
  logic [M_WIDTH-1:0]     step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;

  logic [DWELL_WIDTH-1:0] dwell_last;
  logic                   step_evt;
  logic [SUM_W-1:0]       sum;
  logic signed [SUM_W-1:0] diff;

  // A dwell of zero behaves as one tick per step.
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);
  assign step_evt   = tick && (cnt_q == dwell_last);
  assign sum        = {1'b0, phase_q} + {1'b0, step_q};
  assign diff       = $signed({1'b0, phase_q}) - $signed({1'b0, step_q});

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    mode_d  = mode_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          mode_d  = mode;
          start_d = start_M;
          stop_d  = stop_M;
          step_d  = step_M;
          dwell_d = dwell;
          phase_d = start_M;
          busy_d  = 1'b1;
          cnt_d   = '0;
          wrap_d  = 1'b0;
          if ((mode == 2'b11) || (start_M >= stop_M) || (step_M == '0)) state_d = HOLD;
          else                                                          state_d = RUN_UP;
        end
      end
      RUN_UP, RUN_DOWN: begin
        if (tick) cnt_d = step_evt ? '0 : cnt_q + DWELL_WIDTH'(1);
        if (step_evt) begin
          if (state_q == RUN_UP) begin
            if (wrap_q) begin
              phase_d = start_q;
              wrap_d  = 1'b0;
            end else if (sum < {1'b0, stop_q}) begin
              phase_d = sum[M_WIDTH-1:0];
            end else begin
              phase_d = stop_q;
              case (mode_q)
                2'b01:   begin done_d = 1'b1; wrap_d = 1'b1; end
                2'b10:   state_d = RUN_DOWN;
                default: begin done_d = 1'b1; state_d = HOLD; end
              endcase
            end
          end else begin
            if (diff > $signed({1'b0, start_q})) begin
              phase_d = diff[M_WIDTH-1:0];
            end else begin
              phase_d = start_q;
              done_d  = 1'b1;
              state_d = RUN_UP;
            end
          end
        end
      end
      default: ;
    endcase
    if (done_q) done_d = 1'b0;
    // Dropping enable aborts the run and overrides any coincident step.
    if ((state_q != IDLE) && !enable) begin
      state_d = IDLE;
      phase_d = phase_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      mode_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
    end
  end

  assign phase_M    = phase_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

`ifdef FREQUENCY_SWEEP_MARKER_EN
  logic [M_WIDTH-1:0] mk_q, mk_d;
  logic               entry_q, entry_d;
  logic               marker_q, marker_d;
  logic               step_apply;

  assign step_apply = enable && step_evt && ((state_q == RUN_UP) || (state_q == RUN_DOWN));

  // Flags the step on which phase crosses the marker in the direction of travel.
  always_comb begin
    entry_d  = (state_q == IDLE) && enable;
    mk_d     = entry_d ? marker_M : mk_q;
    marker_d = 1'b0;
    if (enable && entry_q && (phase_q == mk_q)) marker_d = 1'b1;
    if (step_apply) begin
      if ((state_q == RUN_UP) && (phase_q < mk_q) && (phase_d >= mk_q))   marker_d = 1'b1;
      if ((state_q == RUN_DOWN) && (phase_q > mk_q) && (phase_d <= mk_q)) marker_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mk_q     <= '0;
      entry_q  <= 1'b0;
      marker_q <= 1'b0;
    end else begin
      mk_q     <= mk_d;
      entry_q  <= entry_d;
      marker_q <= marker_d;
    end
  end

  assign marker = marker_q;
`endif

endmodule

// File: tb/tb_frequency_sweep.sv
// Scoreboard bench for frequency_sweep: stimulus queues expected outputs, a monitor checks them each cycle.
module tb_frequency_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        enable;
  logic [1:0]  mode;
  logic [9:0]  start_M, stop_M, step_M;
  logic [15:0] dwell;
  logic [9:0]  phase_M;
  logic        busy;
  logic        sweep_done;
`ifdef FREQUENCY_SWEEP_MARKER_EN
  logic [9:0]  marker_M;
  logic        marker;
`endif

  frequency_sweep #(.M_WIDTH(10), .DWELL_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .enable     (enable),
    .mode       (mode),
    .start_M    (start_M),
    .stop_M     (stop_M),
    .step_M     (step_M),
    .dwell      (dwell),
`ifdef FREQUENCY_SWEEP_MARKER_EN
    .marker_M   (marker_M),
    .marker     (marker),
`endif
    .phase_M    (phase_M),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         ph;
    logic       b;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are registered, so every cycle presents a sample to score.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".phase_M"}, int'(phase_M), e.ph);
      chk({e.tag, ".busy"}, int'(busy), int'(e.b));
      chk({e.tag, ".sweep_done"}, int'(sweep_done), int'(e.d));
    end
  end

  task automatic cyc(input string tag, input logic en, input logic tk,
                     input int ph, input logic b, input logic d);
    exp_t e;
    enable = en;
    tick   = tk;
    @(posedge clk);
    e.tag = tag; e.ph = ph; e.b = b; e.d = d;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] m, input int s, input int p, input int st, input int dw);
    mode    = m;
    start_M = 10'(s);
    stop_M  = 10'(p);
    step_M  = 10'(st);
    dwell   = 16'(dw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; enable = 1'b0;
    cfg(2'b00, 0, 0, 0, 0);
`ifdef FREQUENCY_SWEEP_MARKER_EN
    marker_M = 10'd25;
`endif
    repeat (2) @(negedge clk);
    chk("reset.phase_M", int'(phase_M), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.sweep_done", int'(sweep_done), 0);
    rst = 1'b1;
    cyc("idle", 1'b0, 1'b1, 0, 1'b0, 1'b0);

    // Single up sweep with dwell 2.
    cfg(2'b00, 10, 50, 15, 2);
    cyc("up.entry", 1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("up.d1",    1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("up.s25",   1'b1, 1'b1, 25, 1'b1, 1'b0);
    cyc("up.d2",    1'b1, 1'b1, 25, 1'b1, 1'b0);
    cyc("up.s40",   1'b1, 1'b1, 40, 1'b1, 1'b0);
    cyc("up.d3",    1'b1, 1'b1, 40, 1'b1, 1'b0);
    cyc("up.s50",   1'b1, 1'b1, 50, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc("up.hold", 1'b1, 1'b1, 50, 1'b1, 1'b0);
    cyc("up.off",   1'b0, 1'b1, 50, 1'b0, 1'b0);
    cyc("up.idle",  1'b0, 1'b0, 50, 1'b0, 1'b0);

    // Sawtooth; config inputs changed mid-run must be ignored.
    cfg(2'b01, 0, 30, 10, 1);
    cyc("saw.entry", 1'b1, 1'b1, 0, 1'b1, 1'b0);
    cfg(2'b10, 7, 100, 3, 5);
    cyc("saw.s10",  1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("saw.gap",  1'b1, 1'b0, 10, 1'b1, 1'b0);
    cyc("saw.s20",  1'b1, 1'b1, 20, 1'b1, 1'b0);
    cyc("saw.s30",  1'b1, 1'b1, 30, 1'b1, 1'b1);
    cyc("saw.w0",   1'b1, 1'b1, 0,  1'b1, 1'b0);
    cyc("saw.s10b", 1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("saw.s20b", 1'b1, 1'b1, 20, 1'b1, 1'b0);
    cyc("saw.s30b", 1'b1, 1'b1, 30, 1'b1, 1'b1);
    cyc("saw.w0b",  1'b1, 1'b1, 0,  1'b1, 1'b0);
    cyc("saw.off",  1'b0, 1'b1, 0,  1'b0, 1'b0);

    // Triangle.
    cfg(2'b10, 5, 20, 7, 1);
    cyc("tri.entry", 1'b1, 1'b1, 5,  1'b1, 1'b0);
    cyc("tri.u12",   1'b1, 1'b1, 12, 1'b1, 1'b0);
    cyc("tri.u19",   1'b1, 1'b1, 19, 1'b1, 1'b0);
    cyc("tri.u20",   1'b1, 1'b1, 20, 1'b1, 1'b0);
    cyc("tri.d13",   1'b1, 1'b1, 13, 1'b1, 1'b0);
    cyc("tri.d6",    1'b1, 1'b1, 6,  1'b1, 1'b0);
    cyc("tri.d5",    1'b1, 1'b1, 5,  1'b1, 1'b1);
    cyc("tri.u12b",  1'b1, 1'b1, 12, 1'b1, 1'b0);
    cyc("tri.u19b",  1'b1, 1'b1, 19, 1'b1, 1'b0);
    cyc("tri.u20b",  1'b1, 1'b1, 20, 1'b1, 1'b0);
    cyc("tri.off",   1'b0, 1'b1, 20, 1'b0, 1'b0);

    // Degenerate configurations go straight to HOLD.
    cfg(2'b00, 40, 40, 5, 1);
    cyc("eq.entry", 1'b1, 1'b1, 40, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("eq.hold", 1'b1, 1'b1, 40, 1'b1, 1'b0);
    cyc("eq.off",   1'b0, 1'b1, 40, 1'b0, 1'b0);
    cfg(2'b00, 10, 50, 0, 1);
    cyc("s0.entry", 1'b1, 1'b1, 10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("s0.hold", 1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("s0.off",   1'b0, 1'b1, 10, 1'b0, 1'b0);
    cfg(2'b11, 3, 60, 4, 1);
    cyc("fix.entry", 1'b1, 1'b1, 3, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc("fix.hold", 1'b1, 1'b1, 3, 1'b1, 1'b0);
    cyc("fix.off",  1'b0, 1'b1, 3, 1'b0, 1'b0);
    cfg(2'b00, 0, 20, 5, 0);
    cyc("dw0.entry", 1'b1, 1'b1, 0,  1'b1, 1'b0);
    cyc("dw0.s5",    1'b1, 1'b1, 5,  1'b1, 1'b0);
    cyc("dw0.s10",   1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("dw0.s15",   1'b1, 1'b1, 15, 1'b1, 1'b0);
    cyc("dw0.s20",   1'b1, 1'b1, 20, 1'b1, 1'b1);
    cyc("dw0.hold",  1'b1, 1'b1, 20, 1'b1, 1'b0);
    cyc("dw0.off",   1'b0, 1'b1, 20, 1'b0, 1'b0);

    // Abort with a coincident step, restart, then async reset mid-run.
    cfg(2'b00, 10, 50, 15, 1);
    cyc("ab.entry", 1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("ab.s25",   1'b1, 1'b1, 25, 1'b1, 1'b0);
    cyc("ab.off",   1'b0, 1'b1, 25, 1'b0, 1'b0);
    cyc("ab.idle",  1'b0, 1'b1, 25, 1'b0, 1'b0);
    cyc("ab.restart", 1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("ab.s25b",  1'b1, 1'b1, 25, 1'b1, 1'b0);
    cyc("ab.s40",   1'b1, 1'b1, 40, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #2;
    chk("arst.phase_M", int'(phase_M), 0);
    chk("arst.busy", int'(busy), 0);
    chk("arst.sweep_done", int'(sweep_done), 0);
    enable = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    cyc("arst.idle",    1'b0, 1'b1, 0,  1'b0, 1'b0);
    cyc("arst.restart", 1'b1, 1'b1, 10, 1'b1, 1'b0);
    cyc("arst.s25",     1'b1, 1'b1, 25, 1'b1, 1'b0);
    cyc("arst.off",     1'b0, 1'b0, 25, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected samples left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frequency_sweep.md
Name: frequency_sweep

Overview:
- Generates a time-varying phase increment M for the phase accumulator, sweeping DDS output frequency between programmable start and stop increments.
- Sits directly upstream of phase_accumulator and replaces the static phase_M from control_unit when a sweep (chirp) is wanted.
- Steps are paced by a tick input (one pulse per DDS sample) plus a programmable dwell count.

Parameters:
M_WIDTH, 10, width of start/stop/step and of the phase_M output (phase accumulator increment width)
DWELL_WIDTH, 16, width of the dwell counter and the dwell input

Ports:
clk  input  1  system clock (1 MHz domain)
rst  input  1  reset; asynchronous, active-low
tick  input  1  one-clk pulse per DDS sample period; all sweep timing counts these
enable  input  1  level; 1 = run sweep, 0 = return to IDLE
mode  input  2  00 single up, 01 sawtooth repeat, 10 triangle, 11 fixed
start_M  input  M_WIDTH  sweep start increment
stop_M  input  M_WIDTH  sweep end increment
step_M  input  M_WIDTH  increment added or subtracted per step
dwell  input  DWELL_WIDTH  ticks per step; 0 treated as 1
phase_M  output  M_WIDTH  current increment to phase accumulator
busy  output  1  high in RUN_UP/RUN_DOWN/HOLD
sweep_done  output  1  one-clk pulse at sweep completion events

Behaviour:
- Reset (rst=0, async): state IDLE, phase_M=0, busy=0, sweep_done=0, dwell counter=0, latched config=0.
- Config (mode, start_M, stop_M, step_M, dwell) is latched on the IDLE->run transition. Input changes while running are ignored until the next start.
- IDLE: when enable=1, latch config. On the next clk, phase_M=start_M and busy=1. State becomes RUN_UP, or HOLD if mode=11, start_M>=stop_M, or step_M=0.
- Dwell counter:
  - Increments on each clk with tick=1.
  - When tick=1 and counter == max(dwell,1)-1: counter clears and a step occurs.
  - phase_M updates on the clk edge that samples that tick (1 clk latency).
- RUN_UP step: sum = phase_M + step_M computed in M_WIDTH+1 bits.
  - If sum < stop_M: phase_M = sum.
  - Else phase_M = stop_M (saturate; no wrap), and by mode:
    - mode 00: go to HOLD; pulse sweep_done.
    - mode 01: pulse sweep_done. On the next step event phase_M = start_M, stay in RUN_UP.
    - mode 10: go to RUN_DOWN.
- RUN_DOWN step (mode 10 only): diff = phase_M - step_M, signed M_WIDTH+1 bits.
  - If diff > start_M: phase_M = diff.
  - Else phase_M = start_M, pulse sweep_done, go to RUN_UP.
- HOLD: phase_M constant, busy=1, no further sweep_done pulses.
- enable=0 in any run state: next clk state IDLE, busy=0. phase_M holds its last value. Dwell counter clears. sweep_done is not pulsed.
- enable=0 and a step on the same clk: enable wins; no step is applied.
- Async reset mid-sweep: immediate return to reset values. On reset release, IDLE.
- sweep_done is never high for two consecutive clks.

Optional Feature:
- Macro: FREQUENCY_SWEEP_MARKER_EN.
- Defined:
  - Adds input marker_M [M_WIDTH] (latched with config) and output marker [1].
  - marker pulses for one clk on the step in which phase_M moves from below marker_M to >= marker_M (RUN_UP), or from above to <= marker_M (RUN_DOWN).
  - If phase_M equals marker_M at run entry, marker pulses one clk after entry.
  - Reset value of marker is 0.
- Undefined: no marker_M/marker ports and no marker logic; all other behaviour identical.

Test Plan:
- Single up: mode=00, start=10, stop=50, step=15, dwell=2, tick every clk.
  - phase_M goes 10 -> 25 -> 40 -> 50, each step 2 ticks apart.
  - sweep_done pulses once with the 50 update; then HOLD with busy=1.
- Sawtooth: mode=01, start=0, stop=30, step=10, dwell=1.
  - Sequence 0,10,20,30,0,10,... with sweep_done at each 30.
  - Config inputs changed mid-run have no effect.
- Triangle: mode=10, start=5, stop=20, step=7, dwell=1.
  - Sequence 5,12,19,20,13,6,5,12...
  - sweep_done only on the return to 5.
- Degenerate: start=40, stop=40 (and separately step=0, dwell=0).
  - phase_M=40 held, busy=1, no sweep_done.
  - With dwell=0 and a valid range, a step occurs every tick.
- Abort/reset: enable dropped at phase_M=25 while a tick is present.
  - phase_M stays 25, busy=0 next clk.
  - rst=0 asserted asynchronously mid-run clears phase_M to 0 immediately.
  - Restart after release begins from start_M.
- Marker (FREQUENCY_SWEEP_MARKER_EN defined): triangle 0..40, step=10, marker_M=25.
  - marker pulses on the 30 step (up) and on the 20 step (down), one clk each.
